// File: rtl/pc_trace_capture.sv
// PC trace capture: records distinct fetch addresses into a circular history,
// flags a stalled PC, and drives 16 bits of live or browsed address to the display.
module pc_trace_capture #(
    parameter int DEPTH       = 16,
    parameter int STALL_TICKS = 8,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick_i,
    input  logic [31:0]   addr_i,
    input  logic          freeze_i,
    input  logic          step_i,
    input  logic          half_sel_i,
    output logic [15:0]   disp_o,
    output logic          stalled_o,
    output logic          frozen_o,
    output logic [AW:0]   entry_cnt_o,
    output logic [AW-1:0] rd_idx_o
);

    localparam int SW = $clog2(STALL_TICKS + 1);

    typedef enum logic {LIVE, FROZEN} state_t;

    state_t        state, state_n;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, wr_ptr_n;
    logic [AW-1:0] rd_idx, rd_n;
    logic [AW:0]   entry_cnt, cnt_n;
    logic [SW-1:0] stall_cnt, stall_n;
    logic [31:0]   prev;
    logic          have_prev;
    logic          live_tick, push;
    logic [AW-1:0] sel_idx;
    logic [31:0]   sel;

    // A collision between tick_i and freeze_i drops the sample: freeze wins.
    assign live_tick = (state == LIVE) && !freeze_i && tick_i;
    assign push      = live_tick && (!have_prev || (addr_i != prev));
    assign state_n   = freeze_i ? FROZEN : LIVE;

    always_comb begin
        wr_ptr_n = push ? wr_ptr + AW'(1) : wr_ptr;

        cnt_n = entry_cnt;
        if (push && (entry_cnt != (AW+1)'(DEPTH)))
            cnt_n = entry_cnt + (AW+1)'(1);

        stall_n = stall_cnt;
        if (push)
            stall_n = '0;
        else if (live_tick && (stall_cnt != SW'(STALL_TICKS)))
            stall_n = stall_cnt + SW'(1);

        // Browse index is only meaningful while staying FROZEN; it restarts at
        // the newest entry on every entry to FROZEN and reads 0 in LIVE.
        rd_n = rd_idx;
        if ((state_n == LIVE) || (state == LIVE))
            rd_n = '0;
        else if (step_i) begin
            if (entry_cnt == '0)
                rd_n = '0;
            else if (({1'b0, rd_idx} + (AW+1)'(1)) == entry_cnt)
                rd_n = '0;
            else
                rd_n = rd_idx + AW'(1);
        end

        // Display follows next-state values so it lines up with the other
        // registered outputs; a push bypasses the RAM write in flight.
        sel_idx = wr_ptr_n - AW'(1) - rd_n;
        if (cnt_n == '0)
            sel = 32'h0;
        else if (push)
            sel = addr_i;
        else
            sel = mem[sel_idx];
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= addr_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= LIVE;
            frozen_o  <= 1'b0;
            wr_ptr    <= '0;
            rd_idx    <= '0;
            entry_cnt <= '0;
            stall_cnt <= '0;
            stalled_o <= 1'b0;
            prev      <= '0;
            have_prev <= 1'b0;
            disp_o    <= '0;
        end else begin
            state     <= state_n;
            frozen_o  <= (state_n == FROZEN);
            wr_ptr    <= wr_ptr_n;
            rd_idx    <= rd_n;
            entry_cnt <= cnt_n;
            stall_cnt <= stall_n;
            stalled_o <= (stall_n == SW'(STALL_TICKS));
            if (push) begin
                prev      <= addr_i;
                have_prev <= 1'b1;
            end
            disp_o    <= half_sel_i ? sel[31:16] : sel[15:0];
        end
    end

    assign entry_cnt_o = entry_cnt;
    assign rd_idx_o    = rd_idx;

endmodule
